// File: rtl/axi_gpio_irq_ctrl.sv
// ----------------------------------------------------------------------------
// axi_gpio_irq_ctrl
//
// AXI4-Lite slave GPIO block: NUM_OUT byte-strobed output registers that drive
// GPIO_OUT, plus an IN_WIDTH-bit synchronised input port with per-bit edge
// detection, W1C interrupt status and a single registered level IRQ.
//
// Register map (offset = addr[7:0], addr[1:0] ignored):
//   0x00 + 4k  OUT_k       RW   k < NUM_OUT, bits [OUT_WIDTH-1:0]
//   0x40       IN_DATA     RO   synchronised GPIO_IN
//   0x44       IRQ_EN      RW
//   0x48       IRQ_STATUS  W1C  set by edge events (set beats clear)
//   0x4C       EDGE_SEL    RW   0 = rising edge, 1 = falling edge
//   other      unmapped    SLVERR, no state change, read data 0
//
// Ports:
//   ACLK, ARESETn           clock, asynchronous active-low reset
//   S_AW* / S_W* / S_B*     AXI4-Lite write address / data / response
//   S_AR* / S_R*            AXI4-Lite read address / data
//   GPIO_OUT                concatenated OUT registers, reg k at [k*OUT_WIDTH +: OUT_WIDTH]
//   GPIO_IN                 asynchronous inputs
//   IRQ_OUT                 level interrupt, |(IRQ_STATUS & IRQ_EN) registered
// ----------------------------------------------------------------------------
module axi_gpio_irq_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  // Write address channel
  input  logic [ADDR_WIDTH-1:0]        S_AWADDR,
  input  logic                         S_AWVALID,
  output logic                         S_AWREADY,
  // Write data channel
  input  logic [31:0]                  S_WDATA,
  input  logic [3:0]                   S_WSTRB,
  input  logic                         S_WVALID,
  output logic                         S_WREADY,
  // Write response channel
  output logic [1:0]                   S_BRESP,
  output logic                         S_BVALID,
  input  logic                         S_BREADY,
  // Read address channel
  input  logic [ADDR_WIDTH-1:0]        S_ARADDR,
  input  logic                         S_ARVALID,
  output logic                         S_ARREADY,
  // Read data channel
  output logic [31:0]                  S_RDATA,
  output logic [1:0]                   S_RRESP,
  output logic                         S_RVALID,
  input  logic                         S_RREADY,
  // GPIO
  output logic [NUM_OUT*OUT_WIDTH-1:0] GPIO_OUT,
  input  logic [IN_WIDTH-1:0]          GPIO_IN,
  output logic                         IRQ_OUT
);

  // Word indices (addr[7:2]) of the fixed registers.
  localparam logic [5:0] IdxInData    = 6'h10;
  localparam logic [5:0] IdxIrqEn     = 6'h11;
  localparam logic [5:0] IdxIrqStatus = 6'h12;
  localparam logic [5:0] IdxEdgeSel   = 6'h13;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // r_active keeps every READY low while in reset and rises on the first edge after.
  logic                                r_active;

  logic                                r_aw_held;
  logic [5:0]                          r_aw_idx;
  logic                                r_w_held;
  logic [31:0]                         r_wdata;
  logic [3:0]                          r_wstrb;
  logic                                r_bvalid;
  logic [1:0]                          r_bresp;

  logic                                r_rvalid;
  logic [31:0]                         r_rdata;
  logic [1:0]                          r_rresp;

  logic [NUM_OUT-1:0][OUT_WIDTH-1:0]   r_out;
  logic [IN_WIDTH-1:0]                 r_irq_en;
  logic [IN_WIDTH-1:0]                 r_irq_status;
  logic [IN_WIDTH-1:0]                 r_edge_sel;
  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] r_sync;
  logic [IN_WIDTH-1:0]                 r_prev;
  logic                                r_irq;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                                w_aw_hs;
  logic                                w_w_hs;
  logic                                w_ar_hs;
  logic                                w_commit;
  logic [31:0]                         w_wmask;
  logic [OUT_WIDTH-1:0]                w_out_mask;
  logic [IN_WIDTH-1:0]                 w_in_mask;
  logic                                w_wr_ok;
  logic [NUM_OUT-1:0][OUT_WIDTH-1:0]   w_out_d;
  logic [IN_WIDTH-1:0]                 w_irq_en_d;
  logic [IN_WIDTH-1:0]                 w_edge_sel_d;
  logic [IN_WIDTH-1:0]                 w_status_clr;
  logic [IN_WIDTH-1:0]                 w_status_d;
  logic [IN_WIDTH-1:0]                 w_sync;
  logic [IN_WIDTH-1:0]                 w_event;
  logic [5:0]                          w_rd_idx;
  logic [31:0]                         w_rd_data;
  logic                                w_rd_ok;
  logic                                w_unused;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  assign S_AWREADY = r_active & ~r_aw_held & ~r_bvalid;
  assign S_WREADY  = r_active & ~r_w_held & ~r_bvalid;
  assign S_ARREADY = r_active & ~r_rvalid;

  assign w_aw_hs  = S_AWVALID & S_AWREADY;
  assign w_w_hs   = S_WVALID & S_WREADY;
  assign w_ar_hs  = S_ARVALID & S_ARREADY;
  // Address and data both captured: apply the write on this edge.
  assign w_commit = r_aw_held & r_w_held;

  assign S_BVALID = r_bvalid;
  assign S_BRESP  = r_bresp;
  assign S_RVALID = r_rvalid;
  assign S_RDATA  = r_rdata;
  assign S_RRESP  = r_rresp;
  assign GPIO_OUT = r_out;
  assign IRQ_OUT  = r_irq;

  // --------------------------------------------------------------------------
  // Write decode: next values of the RW registers if the held write commits
  // --------------------------------------------------------------------------
  assign w_wmask    = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_out_mask = w_wmask[OUT_WIDTH-1:0];
  assign w_in_mask  = w_wmask[IN_WIDTH-1:0];

  always_comb begin
    w_out_d      = r_out;
    w_irq_en_d   = r_irq_en;
    w_edge_sel_d = r_edge_sel;
    w_status_clr = '0;
    w_wr_ok      = 1'b1;
    if ({26'd0, r_aw_idx} < NUM_OUT) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if ({26'd0, r_aw_idx} == k) begin
          w_out_d[k] = (r_out[k] & ~w_out_mask) | (r_wdata[OUT_WIDTH-1:0] & w_out_mask);
        end
      end
    end else begin
      case (r_aw_idx)
        IdxInData: begin
          // Read-only: accepted with OKAY, nothing changes.
        end
        IdxIrqEn: begin
          w_irq_en_d = (r_irq_en & ~w_in_mask) | (r_wdata[IN_WIDTH-1:0] & w_in_mask);
        end
        IdxIrqStatus: begin
          w_status_clr = r_wdata[IN_WIDTH-1:0] & w_in_mask;
        end
        IdxEdgeSel: begin
          w_edge_sel_d = (r_edge_sel & ~w_in_mask) | (r_wdata[IN_WIDTH-1:0] & w_in_mask);
        end
        default: begin
          w_wr_ok = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Input synchroniser, edge detect and interrupt status
  // --------------------------------------------------------------------------
  assign w_sync  = r_sync[SYNC_STAGES-1];
  // Events compare sync against its own history, so flipping EDGE_SEL alone
  // never produces one.
  assign w_event = (r_edge_sel & r_prev & ~w_sync) | (~r_edge_sel & w_sync & ~r_prev);

  // Clear first, then OR in new events so a coincident event wins.
  assign w_status_d = (r_irq_status & ~(w_status_clr & {IN_WIDTH{w_commit}})) | w_event;

  // --------------------------------------------------------------------------
  // Read decode
  // --------------------------------------------------------------------------
  assign w_rd_idx = S_ARADDR[7:2];

  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = 1'b1;
    if ({26'd0, w_rd_idx} < NUM_OUT) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if ({26'd0, w_rd_idx} == k) begin
          w_rd_data[OUT_WIDTH-1:0] = r_out[k];
        end
      end
    end else begin
      case (w_rd_idx)
        IdxInData:    w_rd_data[IN_WIDTH-1:0] = w_sync;
        IdxIrqEn:     w_rd_data[IN_WIDTH-1:0] = r_irq_en;
        IdxIrqStatus: w_rd_data[IN_WIDTH-1:0] = r_irq_status;
        IdxEdgeSel:   w_rd_data[IN_WIDTH-1:0] = r_edge_sel;
        default:      w_rd_ok = 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_active     <= 1'b0;
      r_aw_held    <= 1'b0;
      r_aw_idx     <= '0;
      r_w_held     <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RespOkay;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= RespOkay;
      r_out        <= '0;
      r_irq_en     <= '0;
      r_irq_status <= '0;
      r_edge_sel   <= '0;
      r_sync       <= '0;
      r_prev       <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_active <= 1'b1;

      // Write channel
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= S_AWADDR[7:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_WDATA;
        r_wstrb  <= S_WSTRB;
      end
      if (w_commit) begin
        r_aw_held  <= 1'b0;
        r_w_held   <= 1'b0;
        r_bvalid   <= 1'b1;
        r_bresp    <= w_wr_ok ? RespOkay : RespSlvErr;
        r_out      <= w_out_d;
        r_irq_en   <= w_irq_en_d;
        r_edge_sel <= w_edge_sel_d;
      end else if (r_bvalid && S_BREADY) begin
        r_bvalid <= 1'b0;
      end

      // Read channel: data is captured once and held until accepted.
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_ok ? RespOkay : RespSlvErr;
      end else if (r_rvalid && S_RREADY) begin
        r_rvalid <= 1'b0;
      end

      // Inputs and interrupts
      r_sync[0] <= GPIO_IN;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev       <= w_sync;
      r_irq_status <= w_status_d;
      r_irq        <= |(r_irq_status & r_irq_en);
    end
  end

  // Address bits outside [7:2] and write-data/strobe bits beyond the register
  // widths are deliberately ignored.
  assign w_unused = ^{S_AWADDR, S_ARADDR, r_wdata, w_wmask};

endmodule

// File: doc/axi_gpio_irq_ctrl.md
Name: axi_gpio_irq_ctrl

Overview:
AXI4-Lite slave peripheral and parametrised successor of the single LED/seven-segment block. It provides NUM_OUT byte-strobed output registers that drive board outputs, and an IN_WIDTH-bit synchronised input port. The input port has per-bit edge-detect interrupts with enable, edge-polarity select, W1C status and a single level IRQ line. AW and W channels are accepted independently, and unmapped accesses return SLVERR.

Parameters:
ADDR_WIDTH, 32, AXI address width; only bits [7:2] are decoded.
NUM_OUT, 4, number of output registers (1..16).
OUT_WIDTH, 8, width of each output register / output lane (1..32).
IN_WIDTH, 8, width of the input port (1..32).
SYNC_STAGES, 2, flops in the input synchroniser (>=2).

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, asynchronous, active-low
S_AWADDR  in  ADDR_WIDTH  write address
S_AWVALID / S_AWREADY  in / out  1  write address handshake
S_WDATA  in  32  write data
S_WSTRB  in  4  byte strobes
S_WVALID / S_WREADY  in / out  1  write data handshake
S_BRESP  out  2  write response
S_BVALID / S_BREADY  out / in  1  write response handshake
S_ARADDR  in  ADDR_WIDTH  read address
S_ARVALID / S_ARREADY  in / out  1  read address handshake
S_RDATA  out  32  read data
S_RRESP  out  2  read response
S_RVALID / S_RREADY  out / in  1  read data handshake
GPIO_OUT  out  NUM_OUT*OUT_WIDTH  concatenated output registers, reg k at [k*OUT_WIDTH +: OUT_WIDTH]
GPIO_IN  in  IN_WIDTH  asynchronous inputs
IRQ_OUT  out  1  level interrupt

Behaviour:
- Reset: all READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, GPIO_OUT 0, IRQ_OUT 0, all registers 0, synchroniser and edge-history flops 0.
- Register map (offset = addr[7:0], addr[1:0] ignored):
  - 0x00+4k, k<NUM_OUT: OUT_k, RW, bits [OUT_WIDTH-1:0]; upper bits read 0.
  - 0x40: IN_DATA, RO, synchronised input.
  - 0x44: IRQ_EN, RW.
  - 0x48: IRQ_STATUS, W1C.
  - 0x4C: EDGE_SEL, RW; bit=0 rising, bit=1 falling.
  - All other offsets are unmapped.
- Write channel:
  - AWREADY=1 while no address is held and BVALID=0. WREADY=1 while no data is held and BVALID=0.
  - Address and data are each captured on their own handshake, in either order or in the same cycle.
  - The cycle after both are held: register update, BVALID=1, holding registers cleared.
  - BVALID holds until BREADY; no new AW/W is accepted while BVALID=1.
- Write semantics:
  - Byte lane i is written only if WSTRB[i]=1; bits beyond the register width are dropped.
  - For IRQ_STATUS, a 1 in a strobed lane clears that bit.
  - Write to IN_DATA: no effect, BRESP=00.
  - Write to an unmapped offset: no state change, BRESP=10 (SLVERR). Otherwise BRESP=00.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake, RDATA/RRESP are registered and RVALID=1 next cycle. RVALID and RDATA are held stable until RREADY.
  - Unmapped read: RDATA=0, RRESP=10.
  - Reads and writes are fully concurrent.
- Input and interrupts:
  - GPIO_IN passes through SYNC_STAGES flops to give sync, plus one history flop prev.
  - Event bit j = EDGE_SEL[j] ? (prev & ~sync) : (sync & ~prev).
  - Event sets IRQ_STATUS[j] regardless of IRQ_EN.
  - If an event and a W1C to the same bit occur in the same cycle, the set wins.
  - IRQ_OUT is registered: IRQ_OUT <= |(IRQ_STATUS & IRQ_EN), one cycle after the status update.
  - Changing EDGE_SEL does not itself generate an event.
- Outputs: GPIO_OUT is driven directly from the OUT registers and changes the cycle the write commits (same edge BVALID rises).
- Reset mid-transaction: all handshake state is abandoned and the block returns to idle immediately; no response is issued afterwards.

Test Plan:
1. AW then W 3 cycles later: addr 0x04, data 0x000000A5, strb 0001 -> GPIO_OUT[15:8]=0xA5 and BVALID=1 the cycle after W handshake, BRESP=00; readback 0x04 returns 0x000000A5.
2. W before AW, and AW+W in the same cycle: addr 0x00, data 0x12345678, strb 0010 -> OUT_0 only takes byte 1 (0x56 if OUT_WIDTH>=16, else unchanged 0x00 for OUT_WIDTH=8); BVALID held for 4 cycles with BREADY=0, with no extra AWREADY/WREADY.
3. IRQ_EN=0x01, EDGE_SEL=0, drive GPIO_IN[0] 0->1 -> IRQ_STATUS=0x01 after SYNC_STAGES+1 cycles, IRQ_OUT=1 one cycle later. Write 0x48 data 0x01 -> IRQ_OUT=0. GPIO_IN[3] rising with EN[3]=0 -> STATUS[3]=1 and IRQ_OUT stays 0.
4. EDGE_SEL[1]=1: GPIO_IN[1] rise gives no status; fall sets STATUS[1]. Time a W1C of bit 1 to the same cycle as a new event -> STATUS[1] stays 1.
5. Read 0x80 and write 0x50 -> RRESP=10 with RDATA=0, BRESP=10; all registers unchanged. Hold RREADY=0 for 5 cycles -> RDATA/RVALID stable and ARREADY=0.
6. Assert ARESETn low while BVALID=1 and a read is pending -> all outputs return to reset values asynchronously; after release, a fresh write to 0x00 completes normally.
